// File: rtl/pio_clkdiv_sched.sv
// Per-SM fractional clock-enable scheduler: one sm_tick pulse every INT + FRAC/256 cycles.
// Optional macro PIO_CLKDIV_FRAC_EN builds the fractional accumulator; without it FRAC is ignored.
module pio_clkdiv_sched #(
  parameter int NUM_SM = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SM-1:0]          sm_en,
  input  logic [NUM_SM-1:0]          clkdiv_restart,
  input  logic [NUM_SM*INT_W-1:0]    clkdiv_int,
  input  logic [NUM_SM*FRAC_W-1:0]   clkdiv_frac,
  output logic [NUM_SM-1:0]          sm_tick,
  output logic [NUM_SM-1:0]          sm_running
);

  localparam logic [INT_W:0] CNT_ONE = {{INT_W{1'b0}}, 1'b1};

  // INT == 0 stands for 2^INT_W, which is why the counter is one bit wider.
  function automatic logic [INT_W:0] int_eff_f(input logic [INT_W-1:0] d);
    if (d == '0) return {1'b1, {INT_W{1'b0}}};
    else         return {1'b0, d};
  endfunction

`ifndef PIO_CLKDIV_FRAC_EN
  logic unused_frac;
  assign unused_frac = ^clkdiv_frac;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) sm_running <= '0;
    else        sm_running <= sm_en;
  end

  for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
    logic [INT_W:0]   cnt;
    logic [INT_W-1:0] div_int;
    logic             carry;

    assign div_int    = clkdiv_int[i*INT_W +: INT_W];
    assign sm_tick[i] = sm_en[i] & (cnt == CNT_ONE) & ~clkdiv_restart[i];

`ifdef PIO_CLKDIV_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] frac_eff;
    logic [FRAC_W:0]   acc_sum;

    // FRAC is meaningless for the 2^INT_W divisor, so the carry is kept at zero there.
    assign frac_eff = (div_int == '0) ? '0 : clkdiv_frac[i*FRAC_W +: FRAC_W];
    assign acc_sum  = {1'b0, acc} + {1'b0, frac_eff};
    assign carry    = acc_sum[FRAC_W];

    always_ff @(posedge clk) begin
      if (!rst_n || clkdiv_restart[i]) acc <= '0;
      else if (sm_tick[i])             acc <= acc_sum[FRAC_W-1:0];
    end
`else
    assign carry = 1'b0;
`endif

    // Restart outranks disable; a disabled SM freezes its phase.
    always_ff @(posedge clk) begin
      if (!rst_n || clkdiv_restart[i]) cnt <= CNT_ONE;
      else if (sm_tick[i])             cnt <= int_eff_f(div_int) + {{INT_W{1'b0}}, carry};
      else if (sm_en[i])               cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pio_clkdiv_sched.sv
// Directed bench for pio_clkdiv_sched; expected tick vectors go through a scoreboard queue.
module tb_pio_clkdiv_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sm_en;
  logic [3:0]  clkdiv_restart;
  logic [63:0] clkdiv_int;
  logic [31:0] clkdiv_frac;
  logic [3:0]  sm_tick;
  logic [3:0]  sm_running;

  int tests  = 0;
  int failed = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_tick;
  int nt;
  int k;

  pio_clkdiv_sched dut (
    .clk(clk), .rst_n(rst_n), .sm_en(sm_en), .clkdiv_restart(clkdiv_restart),
    .clkdiv_int(clkdiv_int), .clkdiv_frac(clkdiv_frac),
    .sm_tick(sm_tick), .sm_running(sm_running)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] exp, input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    last_tick = sm_tick;
    chk(tag, {28'd0, sm_tick}, {28'd0, exp_q.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_div(input int i, input logic [15:0] iv, input logic [7:0] fv);
    clkdiv_int[i*16 +: 16] = iv;
    clkdiv_frac[i*8 +: 8]  = fv;
  endtask

  initial begin
    rst_n = 1'b0; sm_en = '0; clkdiv_restart = '0;
    clkdiv_int = {4{16'd1}}; clkdiv_frac = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_running", {28'd0, sm_running}, 32'd0);
    chk("reset_tick", {28'd0, sm_tick}, 32'd0);
    @(posedge clk); #1;

    // Divide by 1.0 on SM0, others idle
    rst_n = 1'b1; sm_en = 4'b0001;
    @(negedge clk);
    chk("running_lag0", {28'd0, sm_running}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("running_lag1", {28'd0, sm_running}, 32'd1);
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) cyc(4'b0001, "div1");

    // 2.5 divisor after a restart
    set_div(0, 16'd2, 8'd128);
    clkdiv_restart = 4'b0001;
    cyc(4'b0000, "frac_restart");
    clkdiv_restart = '0;
    nt = 0;
    for (int j = 0; j < 25; j++) begin
`ifdef PIO_CLKDIV_FRAC_EN
      cyc(((j % 5 == 0) || (j % 5 == 2)) ? 4'b0001 : 4'b0000, "frac_seq");
`else
      cyc((j % 2 == 0) ? 4'b0001 : 4'b0000, "frac_seq");
`endif
      nt += int'(last_tick[0]);
    end
`ifdef PIO_CLKDIV_FRAC_EN
    chk("frac_count", nt, 10);
`else
    chk("frac_count", nt, 13);
`endif

    // SM2 divide by 5, restart landing on the cnt==1 cycle
    sm_en = 4'b0100; set_div(2, 16'd5, 8'd0);
    for (int j = 0; j <= 16; j++) begin
      clkdiv_restart = (j == 5) ? 4'b0100 : 4'b0000;
      cyc((j == 0 || j == 6 || j == 11 || j == 16) ? 4'b0100 : 4'b0000, "restart_sm2");
    end
    clkdiv_restart = '0;

    // SM0/SM3 phase alignment via simultaneous restart
    clkdiv_frac = '0; sm_en = 4'b1001;
    set_div(0, 16'd3, 8'd0); set_div(3, 16'd7, 8'd0);
    run(10);
    clkdiv_restart = 4'b1001;
    set_div(0, 16'd4, 8'd0); set_div(3, 16'd4, 8'd0);
    cyc(4'b0000, "align_restart");
    clkdiv_restart = '0;
    for (int j = 1; j <= 13; j++) cyc(((j - 1) % 4 == 0) ? 4'b1001 : 4'b0000, "align");

    // Divisor change mid-period, then reset mid-period
    sm_en = 4'b0001; set_div(0, 16'd3, 8'd0);
    clkdiv_restart = 4'b0001;
    cyc(4'b0000, "chg_restart");
    clkdiv_restart = '0;
    for (int j = 1; j <= 24; j++) begin
      if (j == 5) set_div(0, 16'd7, 8'd0);
      cyc((j == 1 || j == 4 || j == 7 || j == 14 || j == 21) ? 4'b0001 : 4'b0000, "div_change");
    end
    rst_n = 1'b0;
    cyc(4'b0000, "mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_running_clr", {28'd0, sm_running}, 32'd0);
    @(posedge clk); #1;
    run(0);
    for (int j = 27; j <= 33; j++) cyc((j == 33) ? 4'b0001 : 4'b0000, "post_reset");

    // INT=0 divides by 65536; a 100-cycle disable stretches the period
    sm_en = 4'b0010; set_div(1, 16'd0, 8'd200); set_div(0, 16'd1, 8'd0);
    cyc(4'b0010, "int0_first");
    for (k = 1; k < 70000; k++) begin
      sm_en = (k >= 1000 && k < 1100) ? 4'b0000 : 4'b0010;
      @(negedge clk);
      if (sm_tick[1]) break;
      @(posedge clk); #1;
    end
    chk("int0_period", k, 65636);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
